mul_unit_seq: RTL and testbench

//  Iterative shift-add multiplier serving the controller's multiply requests
//  (MUL, UMULL, SMULL), i.e. the datapath-side responder to opMul/IsLongMul.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_cond_neg.sv | 14 +
 rtl/mul_unit_seq.sv | 139 +++++++++++++
 tb/tb_mul_unit_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding and default width.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_cond_neg.sv
// N-bit conditional two's-complement negate: y = neg ? -a : a.
module mul_cond_neg #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic         neg_i,
    output logic [N-1:0] y_o
);

    always_comb begin
        y_o = neg_i ? (~a_i + {{(N-1){1'b0}}, 1'b1}) : a_i;
    end

endmodule

// File: rtl/mul_unit_seq.sv
// Radix-2 shift-add multiplier for MUL/UMULL/SMULL: WIDTH CALC cycles, one DONE cycle.
// Signed long multiplies run on magnitudes; the sign is reapplied to the final product.
module mul_unit_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             IsLongMul,
    input  logic             IsSigned,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_e state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mplier_q, acc_hi_q;
    logic [CW-1:0]    count_q;
    logic             neg_q, long_q;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;
    logic [1:0]       flags_q;

    logic             op_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_hi_n, mplier_n;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0] prod_hi;
    logic             flag_n, flag_z;

    assign op_signed = IsLongMul & IsSigned;

    mul_cond_neg #(.N(WIDTH)) u_abs_a (
        .a_i   (SrcA),
        .neg_i (op_signed & SrcA[WIDTH-1]),
        .y_o   (abs_a)
    );

    mul_cond_neg #(.N(WIDTH)) u_abs_b (
        .a_i   (SrcB),
        .neg_i (op_signed & SrcB[WIDTH-1]),
        .y_o   (abs_b)
    );

    // One shift-add step; on the last CALC cycle this is already the full product.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = {1'b0, acc_hi_q} + {1'b0, addend};
        acc_hi_n = sum[WIDTH:1];
        mplier_n = {sum[0], mplier_q[WIDTH-1:1]};
        prod_raw = {acc_hi_n, mplier_n};
    end

    mul_cond_neg #(.N(2 * WIDTH)) u_neg_prod (
        .a_i   (prod_raw),
        .neg_i (neg_q),
        .y_o   (prod)
    );

    always_comb begin
        prod_hi = long_q ? prod[2*WIDTH-1:WIDTH] : '0;
        flag_n  = long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
        flag_z  = long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (start) state_d = MUL_CALC;
            MUL_CALC: if (count_q == LAST) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            long_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        mcand_q  <= abs_a;
                        mplier_q <= abs_b;
                        neg_q    <= op_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        long_q   <= IsLongMul;
                        acc_hi_q <= '0;
                        count_q  <= '0;
                    end
                end
                MUL_CALC: begin
                    acc_hi_q <= acc_hi_n;
                    mplier_q <= mplier_n;
                    count_q  <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        res_lo_q <= prod[WIDTH-1:0];
                        res_hi_q <= prod_hi;
                        flags_q  <= {flag_n, flag_z};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != MUL_IDLE);
    assign done     = (state_q == MUL_DONE);
    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;
    assign MulFlags = flags_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Directed bench for mul_unit_seq: products, flags, latency, ignored starts, back-to-back, abort.
module tb_mul_unit_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        IsLongMul = 1'b0;
    logic        IsSigned = 1'b0;
    logic        busy, done;
    logic [31:0] ResultLo, ResultHi;
    logic [1:0]  MulFlags;

    int errors = 0;
    int checks = 0;

    mul_unit_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .IsLongMul (IsLongMul),
        .IsSigned  (IsSigned),
        .busy      (busy),
        .done      (done),
        .ResultLo  (ResultLo),
        .ResultHi  (ResultHi),
        .MulFlags  (MulFlags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op; cycle 1 is the cycle after the start edge. Operands are scrambled
    // after the start edge, start is optionally re-pulsed at poke_at or held high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic lng,
                          input logic sgn, input int poke_at, input bit hold,
                          output int first_done, output int second_done, output int n_done,
                          output int n_busy, output logic [31:0] lo, output logic [31:0] hi,
                          output logic [1:0] fl);
        first_done = 0; second_done = 0; n_done = 0; n_busy = 0;
        lo = '0; hi = '0; fl = '0;
        @(negedge clk);
        SrcA = a; SrcB = b; IsLongMul = lng; IsSigned = sgn; start = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_done = cyc; lo = ResultLo; hi = ResultHi; fl = MulFlags;
                end else if (n_done == 2) begin
                    second_done = cyc;
                end
            end
            if (cyc == 1) begin
                SrcA = ~a; SrcB = ~b;
            end
            start = (hold && cyc < 40) || (cyc == poke_at);
        end
        start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic lng, input logic sgn, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic [1:0] exp_fl, input int poke_at);
        int fd, sd, nd, nb;
        logic [31:0] lo, hi;
        logic [1:0]  fl;
        run_op(a, b, lng, sgn, poke_at, 1'b0, fd, sd, nd, nb, lo, hi, fl);
        check({tag, ".lo"},       64'(lo), 64'(exp_lo));
        check({tag, ".hi"},       64'(hi), 64'(exp_hi));
        check({tag, ".flags"},    64'(fl), 64'(exp_fl));
        check({tag, ".done_cyc"}, 64'(fd), 64'd33);
        check({tag, ".n_done"},   64'(nd), 64'd1);
        check({tag, ".n_busy"},   64'(nb), 64'd33);
        check({tag, ".hold_lo"},  64'(ResultLo), 64'(exp_lo));
        check({tag, ".hold_hi"},  64'(ResultHi), 64'(exp_hi));
    endtask

    initial begin
        int fd, sd, nd, nb, rdone;
        logic [31:0] lo, hi;
        logic [1:0]  fl;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy",  64'(busy), 64'd0);
        check("rst.done",  64'(done), 64'd0);
        check("rst.lo",    64'(ResultLo), 64'd0);
        check("rst.hi",    64'(ResultHi), 64'd0);
        check("rst.flags", 64'(MulFlags), 64'd0);

        do_op("umull_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
              32'hFFFF_FFFE, 32'h0000_0001, 2'b10, 0);
        do_op("smull_m1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0);
        do_op("smull_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1,
              32'h4000_0000, 32'h0000_0000, 2'b00, 0);
        do_op("mul_zero",  32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1,
              32'h0000_0000, 32'h0000_0000, 2'b01, 0);
        do_op("smull_neg", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 2'b10, 0);
        do_op("umull_sm",  32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0,
              32'h0000_0000, 32'h0000_000F, 2'b00, 0);
        do_op("mul_ovf",   32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0,
              32'h0000_0000, 32'hFFFF_FFFE, 2'b10, 0);
        do_op("poke",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
              32'hFFFF_FFFE, 32'h0000_0001, 2'b10, 5);

        // Start held high through DONE relaunches on the first IDLE edge.
        run_op(32'h3, 32'h5, 1'b1, 1'b0, 0, 1'b1, fd, sd, nd, nb, lo, hi, fl);
        check("b2b.lo",     64'(lo), 64'h0000_000F);
        check("b2b.first",  64'(fd), 64'd33);
        check("b2b.second", 64'(sd), 64'd67);
        check("b2b.n_done", 64'(nd), 64'd2);

        // Abort in the 10th CALC cycle; outputs still hold a nonzero product here.
        rdone = 0;
        @(negedge clk);
        SrcA = 32'd7; SrcB = 32'd6; IsLongMul = 1'b1; IsSigned = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) rdone++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy",  64'(busy), 64'd0);
        check("abort.done",  64'(done), 64'd0);
        check("abort.lo",    64'(ResultLo), 64'd0);
        check("abort.hi",    64'(ResultHi), 64'd0);
        check("abort.flags", 64'(MulFlags), 64'd0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) rdone++;
        end
        check("abort.no_done", 64'(rdone), 64'd0);

        do_op("after_abort", 32'd7, 32'd6, 1'b1, 1'b0, 32'h0, 32'h0000_002A, 2'b00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
